// File: rtl/obi_mem_pkg.sv
// Shared types and constants for the OBI memory responder.
package obi_mem_pkg;

  localparam int unsigned DATA_W         = 32;
  localparam int unsigned BE_W           = 4;
  localparam int unsigned MEM_WORDS_DFLT = 1024;
  localparam int unsigned MEM_IDX_W      = $clog2(MEM_WORDS_DFLT);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              err;
  } resp_t;

endpackage

// File: rtl/obi_mem_responder_if.sv
// OBI address/response bus between an initiator and the memory responder.
// The r_err wire exists only when OBI_MEM_ERR_EN is defined.
interface obi_mem_responder_if
  import obi_mem_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W_P = 32
) ();

  logic                req;
  logic                gnt;
  logic [ADDR_W-1:0]   addr;
  logic                we;
  logic [DATA_W_P-1:0] w_data;
  logic [BE_W-1:0]     be;
  logic                r_valid;
  logic [DATA_W_P-1:0] r_data;
`ifdef OBI_MEM_ERR_EN
  logic                r_err;
`endif

  modport master (
    output req, addr, we, w_data, be,
`ifdef OBI_MEM_ERR_EN
    input  r_err,
`endif
    input  gnt, r_valid, r_data
  );

  modport slave (
    input  req, addr, we, w_data, be,
`ifdef OBI_MEM_ERR_EN
    output r_err,
`endif
    output gnt, r_valid, r_data
  );

endinterface

// File: rtl/obi_mem_be_ram.sv
// Single-port RAM: synchronous byte-enabled write, combinational read.
// Contents are deliberately not reset.
module obi_mem_be_ram
  import obi_mem_pkg::*;
#(
  parameter int unsigned IDX_W  = MEM_IDX_W,
  parameter int unsigned WORD_W = DATA_W
) (
  input  logic              i_clk,
  input  logic              i_we,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [WORD_W-1:0] o_rdata
);

  localparam int unsigned WORDS = 1 << IDX_W;

  logic [WORD_W-1:0] r_mem [WORDS];

  // Byte-lane write; lanes with a clear enable keep their old contents.
  always_ff @(posedge i_clk) begin
    if (i_we) begin
      for (int b = 0; b < int'(BE_W); b++) begin
        if (i_be[b]) begin
          r_mem[i_idx][8*b +: 8] <= i_wdata[8*b +: 8];
        end
      end
    end
  end

  assign o_rdata = r_mem[i_idx];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI responder backed by a word-addressed RAM, with programmable grant wait
// states and fixed response latency. Define OBI_MEM_ERR_EN to add r_err.
module obi_mem_responder
  import obi_mem_pkg::*;
#(
  parameter int unsigned OBI_ADDR_WIDTH = 32,
  parameter int unsigned OBI_DATA_WIDTH = 32,
  parameter int unsigned MEM_WORDS      = MEM_WORDS_DFLT,
  parameter int unsigned GNT_WAIT       = 0,
  parameter int unsigned RESP_LAT       = 1
) (
  input  logic          obi_aclk,
  input  logic          obi_aresetn,
  obi_mem_responder_if.slave obi_slave
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam int unsigned CNT_W = (GNT_WAIT > 0) ? $clog2(GNT_WAIT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(GNT_WAIT);

  state_t                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  logic                      w_gnt;
  logic                      w_in_range;
  logic                      w_wr;
  logic [IDX_W-1:0]          w_idx;
  logic [OBI_DATA_WIDTH-1:0] w_ram_rdata;
  resp_t                     w_resp_in;
  logic [1:0]                w_unused_addr;

  // Grant decision; held low during reset so nothing commits in a reset cycle.
  always_comb begin
    w_gnt = 1'b0;
    if (obi_aresetn && obi_slave.req) begin
      case (r_state)
        IDLE:    w_gnt = (GNT_WAIT == 0);
        WAIT:    w_gnt = (r_cnt == CNT_MAX);
        default: w_gnt = 1'b0;
      endcase
    end else begin
      w_gnt = 1'b0;
    end
  end

  // Wait-state FSM; a dropped req abandons the pending request.
  always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
    if (!obi_aresetn) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (obi_slave.req && (GNT_WAIT != 0)) begin
            r_state <= WAIT;
            r_cnt   <= CNT_W'(1);
          end else begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end
        end
        WAIT: begin
          if (!obi_slave.req || (r_cnt == CNT_MAX)) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else begin
            r_state <= WAIT;
            r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state <= IDLE;
          r_cnt   <= '0;
        end
      endcase
    end
  end

  assign w_idx         = obi_slave.addr[2 +: IDX_W];
  assign w_unused_addr = obi_slave.addr[1:0];
  // Upper address bits must be zero: out-of-range accesses never alias.
  assign w_in_range    = (obi_slave.addr[OBI_ADDR_WIDTH-1:IDX_W+2] == '0);
  assign w_wr          = w_gnt & obi_slave.we & w_in_range;

  obi_mem_be_ram #(
    .IDX_W  (IDX_W),
    .WORD_W (OBI_DATA_WIDTH)
  ) u_ram (
    .i_clk   (obi_aclk),
    .i_we    (w_wr),
    .i_idx   (w_idx),
    .i_wdata (obi_slave.w_data),
    .i_be    (obi_slave.be),
    .o_rdata (w_ram_rdata)
  );

  // Response captured on the granted cycle; writes and bad reads carry zero data.
  always_comb begin
    w_resp_in.valid = w_gnt;
    if (w_gnt && !obi_slave.we && w_in_range) begin
      w_resp_in.data = w_ram_rdata;
    end else begin
      w_resp_in.data = '0;
    end
`ifdef OBI_MEM_ERR_EN
    w_resp_in.err = w_gnt & ~w_in_range;
`else
    w_resp_in.err = 1'b0;
`endif
  end

  for (genvar g = 0; g < int'(RESP_LAT); g++) begin : g_stage
    resp_t w_in;
    resp_t r_q;

    if (g == 0) begin : g_first
      assign w_in = w_resp_in;
    end else begin : g_next
      assign w_in = g_stage[g-1].r_q;
    end

    // Shift stage; data only changes on a valid entry so r_data holds between pulses.
    always_ff @(posedge obi_aclk or negedge obi_aresetn) begin
      if (!obi_aresetn) begin
        r_q <= '0;
      end else begin
        r_q.valid <= w_in.valid;
        r_q.err   <= w_in.valid & w_in.err;
        if (w_in.valid) begin
          r_q.data <= w_in.data;
        end else begin
          r_q.data <= r_q.data;
        end
      end
    end
  end

  assign obi_slave.gnt     = w_gnt;
  assign obi_slave.r_valid = g_stage[RESP_LAT-1].r_q.valid;
  assign obi_slave.r_data  = g_stage[RESP_LAT-1].r_q.data;
`ifdef OBI_MEM_ERR_EN
  assign obi_slave.r_err   = g_stage[RESP_LAT-1].r_q.err;
`else
  logic w_unused_err;
  assign w_unused_err = g_stage[RESP_LAT-1].r_q.err;
`endif

endmodule

// File: tb/tb_obi_mem_responder.sv
// Directed bench for obi_mem_responder: three instances cover same-cycle grant,
// wait-state grant with mid-flight reset, and a 3-deep response pipeline.
module tb_obi_mem_responder;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   n_cmp = 0;
  int   n_mis = 0;
  int   cyc;

  always #5 clk = ~clk;

  obi_mem_responder_if ifa ();
  obi_mem_responder_if ifb ();
  obi_mem_responder_if ifc ();

  obi_mem_responder #(.GNT_WAIT(0), .RESP_LAT(1)) u_a (.obi_aclk(clk), .obi_aresetn(rst_a), .obi_slave(ifa));
  obi_mem_responder #(.GNT_WAIT(3), .RESP_LAT(2)) u_b (.obi_aclk(clk), .obi_aresetn(rst_b), .obi_slave(ifb));
  obi_mem_responder #(.GNT_WAIT(0), .RESP_LAT(3)) u_c (.obi_aclk(clk), .obi_aresetn(rst_a), .obi_slave(ifc));

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] exp;
    logic        err;
  } vec_t;

  vec_t va [11];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Hold req on ifb until granted (bounded); cyc = grant cycle index, 0 if never.
  task automatic b_req_until_gnt(input logic we, input logic [31:0] addr, input logic [31:0] wd, output int c);
    c = 0;
    @(posedge clk); #1;
    ifb.req = 1'b1; ifb.we = we; ifb.addr = addr; ifb.w_data = wd; ifb.be = 4'hF;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (ifb.gnt) begin
        c = k;
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    ifb.req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    va[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0000_0000, 1'b0};
    va[1]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDEAD_BEEF, 1'b0};
    va[2]  = '{1'b1, 32'h0000_0010, 32'h1122_3344, 4'h5, 32'h0000_0000, 1'b0};
    va[3]  = '{1'b0, 32'h0000_0010, 32'h0000_0000, 4'hF, 32'hDE22_BE44, 1'b0};
    va[4]  = '{1'b1, 32'h0000_0010, 32'hFFFF_FFFF, 4'h0, 32'h0000_0000, 1'b0};
    va[5]  = '{1'b0, 32'h0000_0013, 32'h0000_0000, 4'hF, 32'hDE22_BE44, 1'b0};
    va[6]  = '{1'b1, 32'h0000_0000, 32'hA5A5_A5A5, 4'hF, 32'h0000_0000, 1'b0};
    va[7]  = '{1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 32'h0000_0000, 1'b1};
    va[8]  = '{1'b0, 32'h0000_1000, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};
    va[9]  = '{1'b0, 32'h0000_0000, 32'h0000_0000, 4'hF, 32'hA5A5_A5A5, 1'b0};
    va[10] = '{1'b0, 32'h8000_0010, 32'h0000_0000, 4'hF, 32'h0000_0000, 1'b1};

    rst_a = 1'b0; rst_b = 1'b0;
    ifa.req = 1'b1; ifa.we = 1'b0; ifa.addr = '0; ifa.w_data = '0; ifa.be = 4'hF;
    ifb.req = 1'b0; ifb.we = 1'b0; ifb.addr = '0; ifb.w_data = '0; ifb.be = 4'hF;
    ifc.req = 1'b0; ifc.we = 1'b0; ifc.addr = '0; ifc.w_data = '0; ifc.be = 4'hF;
    repeat (2) @(negedge clk);
    check_eq("rst_a_gnt", 32'(ifa.gnt), 32'd0);
    check_eq("rst_a_rvalid", 32'(ifa.r_valid), 32'd0);
    check_eq("rst_a_rdata", ifa.r_data, 32'd0);
    check_eq("rst_b_rvalid", 32'(ifb.r_valid), 32'd0);
    check_eq("rst_c_rvalid", 32'(ifc.r_valid), 32'd0);
`ifdef OBI_MEM_ERR_EN
    check_eq("rst_a_rerr", 32'(ifa.r_err), 32'd0);
`endif
    @(posedge clk); #1;
    ifa.req = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1;

    // A: same-cycle grant, one-cycle response
    foreach (va[i]) begin
      @(posedge clk); #1;
      ifa.req = 1'b1; ifa.we = va[i].we; ifa.addr = va[i].addr; ifa.w_data = va[i].wdata; ifa.be = va[i].be;
      @(negedge clk);
      check_eq($sformatf("a%0d_gnt", i), 32'(ifa.gnt), 32'd1);
      @(posedge clk); #1;
      ifa.req = 1'b0;
      @(negedge clk);
      check_eq($sformatf("a%0d_rvalid", i), 32'(ifa.r_valid), 32'd1);
      check_eq($sformatf("a%0d_rdata", i), ifa.r_data, va[i].exp);
`ifdef OBI_MEM_ERR_EN
      check_eq($sformatf("a%0d_rerr", i), 32'(ifa.r_err), 32'(va[i].err));
`endif
      @(negedge clk);
      check_eq($sformatf("a%0d_pulse", i), 32'(ifa.r_valid), 32'd0);
      check_eq($sformatf("a%0d_hold", i), ifa.r_data, va[i].exp);
    end

    // A: back-to-back write then read of the same word
    @(posedge clk); #1;
    ifa.req = 1'b1; ifa.we = 1'b1; ifa.addr = 32'h20; ifa.w_data = 32'hCAFE_F00D; ifa.be = 4'hF;
    @(negedge clk);
    check_eq("raw_w_gnt", 32'(ifa.gnt), 32'd1);
    @(posedge clk); #1;
    ifa.we = 1'b0;
    @(negedge clk);
    check_eq("raw_r_gnt", 32'(ifa.gnt), 32'd1);
    check_eq("raw_w_rvalid", 32'(ifa.r_valid), 32'd1);
    check_eq("raw_w_rdata", ifa.r_data, 32'd0);
    @(posedge clk); #1;
    ifa.req = 1'b0;
    @(negedge clk);
    check_eq("raw_r_rvalid", 32'(ifa.r_valid), 32'd1);
    check_eq("raw_r_rdata", ifa.r_data, 32'hCAFE_F00D);

    // B: grant on the 4th cycle of req, response two cycles after grant
    b_req_until_gnt(1'b1, 32'h40, 32'h0BAD_C0DE, cyc);
    check_eq("b_w_gnt_cycle", 32'(cyc), 32'd4);
    @(negedge clk);
    check_eq("b_w_lat1", 32'(ifb.r_valid), 32'd0);
    @(negedge clk);
    check_eq("b_w_lat2", 32'(ifb.r_valid), 32'd1);
    check_eq("b_w_rdata", ifb.r_data, 32'd0);

    // B: req abandoned after one cycle
    @(posedge clk); #1;
    ifb.req = 1'b1; ifb.we = 1'b0; ifb.addr = 32'h40;
    @(negedge clk);
    check_eq("b_drop_gnt", 32'(ifb.gnt), 32'd0);
    @(posedge clk); #1;
    ifb.req = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_eq($sformatf("b_drop_rvalid%0d", k), 32'(ifb.r_valid), 32'd0);
    end
    b_req_until_gnt(1'b0, 32'h40, 32'h0, cyc);
    check_eq("b_after_drop_gnt_cycle", 32'(cyc), 32'd4);
    repeat (2) @(negedge clk);
    check_eq("b_r_rvalid", 32'(ifb.r_valid), 32'd1);
    check_eq("b_r_rdata", ifb.r_data, 32'h0BAD_C0DE);

    // B: reset one cycle after a read grant drops the in-flight response
    b_req_until_gnt(1'b0, 32'h40, 32'h0, cyc);
    check_eq("b_pre_rst_gnt_cycle", 32'(cyc), 32'd4);
    rst_b = 1'b0;
    ifb.req = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq($sformatf("b_in_rst_gnt%0d", k), 32'(ifb.gnt), 32'd0);
      check_eq($sformatf("b_in_rst_rvalid%0d", k), 32'(ifb.r_valid), 32'd0);
    end
    @(posedge clk); #1;
    ifb.req = 1'b0;
    rst_b = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check_eq($sformatf("b_post_rst_rvalid%0d", k), 32'(ifb.r_valid), 32'd0);
    end
    b_req_until_gnt(1'b0, 32'h40, 32'h0, cyc);
    check_eq("b_retain_gnt_cycle", 32'(cyc), 32'd4);
    repeat (2) @(negedge clk);
    check_eq("b_retain_rvalid", 32'(ifb.r_valid), 32'd1);
    check_eq("b_retain_rdata", ifb.r_data, 32'h0BAD_C0DE);

    // C: preload words 0..3 with 1..4 on consecutive cycles
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      ifc.req = 1'b1; ifc.we = 1'b1; ifc.addr = 32'(k * 4); ifc.w_data = 32'(k + 1); ifc.be = 4'hF;
      @(negedge clk);
      check_eq($sformatf("c_w%0d_gnt", k), 32'(ifc.gnt), 32'd1);
    end
    @(posedge clk); #1;
    ifc.req = 1'b0;
    repeat (4) @(posedge clk);

    // C: four back-to-back reads, responses three cycles later in order
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      if (c < 4) begin
        ifc.req = 1'b1; ifc.we = 1'b0; ifc.addr = 32'(c * 4);
      end else begin
        ifc.req = 1'b0;
      end
      @(negedge clk);
      if (c < 4) check_eq($sformatf("c_r%0d_gnt", c), 32'(ifc.gnt), 32'd1);
      check_eq($sformatf("c_cyc%0d_rvalid", c), 32'(ifc.r_valid), 32'(c >= 3 && c <= 6));
      if (c >= 3 && c <= 6) check_eq($sformatf("c_cyc%0d_rdata", c), ifc.r_data, 32'(c - 2));
    end
    check_eq("c_hold_rdata", ifc.r_data, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
